// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: pipeline writeback, long-result handshake, scoreboard query and
// register-file write signals of the write-port arbiter.
interface rf_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_hold;
  logic        long_valid;
  logic        long_ready;
  logic [4:0]  long_waddr;
  logic [31:0] long_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_rs;
  logic [4:0]  query_rt;
  logic        busy_rs;
  logic        busy_rt;
  logic        pending_any;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  modport slave (
    input  wb_valid, wb_waddr, wb_wdata, long_valid, long_waddr, long_wdata,
           issue_valid, issue_rd, query_rs, query_rt,
    output wb_hold, long_ready, busy_rs, busy_rt, pending_any, rf_wen, rf_waddr, rf_wdata
  );
  modport master (
    output wb_valid, wb_waddr, wb_wdata, long_valid, long_waddr, long_wdata,
           issue_valid, issue_rd, query_rs, query_rt,
    input  wb_hold, long_ready, busy_rs, busy_rt, pending_any, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges pipeline writeback and buffered long-latency results onto the
// register-file write port, with a pending-register scoreboard and starvation hold.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [36:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stv_q, stv_d;
  logic          hold_q, hold_d, wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d, head_a;
  logic [31:0]   wdata_q, wdata_d, head_d, pend_q, pend_d;
  logic          push, pop;
  // pop decision uses the registered count, so a result never leaves in its arrival cycle
  always_comb begin
    {head_a, head_d} = mem_q[rd_q];
    push = bus.long_valid && cnt_q < CW'(FIFO_DEPTH);
    pop = !bus.wb_valid && cnt_q != '0;
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    waddr_d = bus.wb_valid ? bus.wb_waddr : head_a;
    wdata_d = bus.wb_valid ? bus.wb_wdata : head_d;
    wen_d = (bus.wb_valid || pop) && waddr_d != '0;
    stv_d = pop ? '0 : (cnt_q != '0 && bus.wb_valid && stv_q != SW'(STARVE_LIMIT)) ? stv_q + 1'b1 : stv_q;
    hold_d = !pop && (hold_q || stv_d == SW'(STARVE_LIMIT));
    pend_d = pend_q;
    if (pop) pend_d[head_a] = 1'b0;
    if (bus.issue_valid) pend_d[bus.issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      stv_q   <= '0;
      hold_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      stv_q   <= stv_d;
      hold_q  <= hold_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
    if (push) mem_q[wr_q] <= {bus.long_waddr, bus.long_wdata};
  end
  assign bus.long_ready  = cnt_q < CW'(FIFO_DEPTH);
  assign bus.wb_hold     = hold_q;
  assign bus.busy_rs     = pend_q[bus.query_rs];
  assign bus.busy_rt     = pend_q[bus.query_rt];
  assign bus.pending_any = (|pend_q) || cnt_q != '0;
  assign bus.rf_wen      = wen_q;
  assign bus.rf_waddr    = waddr_q;
  assign bus.rf_wdata    = wdata_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table vectors, hand-written corner sequences and randomized traffic
// checked against a queue-based reference model of the write arbiter.
module tb_rf_write_arbiter;
  localparam int D = 4;
  localparam int L = 3;
  typedef struct {
    logic rst, wv;
    logic [4:0] wa;
    logic [31:0] wd;
    logic lv;
    logic [4:0] la;
    logic [31:0] ld;
    logic iv;
    logic [4:0] ir, rs, rt;
  } in_t;
  typedef struct {
    in_t i;
    logic e_wen;
    logic [4:0] e_wa;
    logic [31:0] e_wd;
    logic e_rdy, e_brs, e_pany, e_hold;
  } vec_t;
  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
  } ent_t;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int fails = 0;
  rf_write_arbiter_if b();
  rf_write_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  ent_t q[$];
  logic [31:0] pend;
  logic m_wen, m_hold, m_ad;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  int starve;
  vec_t tv[9];
  function automatic in_t mk(logic wv, logic [4:0] wa, logic [31:0] wd, logic lv, logic [4:0] la,
                             logic [31:0] ld, logic iv, logic [4:0] ir);
    in_t x;
    x = '{1'b0, wv, wa, wd, lv, la, ld, iv, ir, 5'd9, 5'd3};
    return x;
  endfunction
  function automatic in_t rstv();
    in_t x;
    x = mk(0, 0, 0, 0, 0, 0, 0, 0);
    x.rst = 1'b1;
    return x;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // reference: priority pick, FIFO as a queue, scoreboard as a bit array
  task automatic model(input in_t x);
    int n;
    ent_t h;
    logic pop, push;
    n = q.size();
    pop = !x.wv && n > 0;
    push = x.lv && n < D;
    if (x.rst) begin
      q.delete();
      pend = 0; m_wen = 0; m_wa = 0; m_wd = 0; m_hold = 0; starve = 0; m_ad = 1;
      return;
    end
    m_ad = 0;
    m_wen = 0;
    if (x.wv) begin
      m_wen = x.wa != 0; m_wa = x.wa; m_wd = x.wd;
    end else if (pop) begin
      h = q.pop_front();
      m_wen = h.a != 0; m_wa = h.a; m_wd = h.d;
      pend[h.a] = 1'b0;
    end
    if (x.iv && x.ir != 0) pend[x.ir] = 1'b1;
    if (push) q.push_back('{x.la, x.ld});
    if (pop) begin
      starve = 0; m_hold = 0;
    end else begin
      if (n > 0 && x.wv && starve < L) starve++;
      if (starve >= L) m_hold = 1;
    end
  endtask
  task automatic check_model(input in_t x);
    chk("rf_wen", b.rf_wen, m_wen);
    if (m_wen || m_ad) begin
      chk("rf_waddr", b.rf_waddr, m_wa);
      chk("rf_wdata", b.rf_wdata, m_wd);
    end
    chk("long_ready", b.long_ready, q.size() < D);
    chk("wb_hold", b.wb_hold, m_hold);
    chk("busy_rs", b.busy_rs, x.rs != 0 && pend[x.rs]);
    chk("busy_rt", b.busy_rt, x.rt != 0 && pend[x.rt]);
    chk("pending_any", b.pending_any, pend != 0 || q.size() != 0);
  endtask
  task automatic step(input in_t x);
    @(negedge clk);
    rst = x.rst;
    b.wb_valid = x.wv; b.wb_waddr = x.wa; b.wb_wdata = x.wd;
    b.long_valid = x.lv; b.long_waddr = x.la; b.long_wdata = x.ld;
    b.issue_valid = x.iv; b.issue_rd = x.ir; b.query_rs = x.rs; b.query_rt = x.rt;
    #1;
    if (!x.rst)
      assert (!(b.wb_valid && b.wb_hold)) else begin
        fails++;
        $display("FAIL protocol: wb_valid while wb_hold at %0t", $time);
      end
    model(x);
    @(posedge clk);
    #1;
    check_model(x);
  endtask
  initial begin
    in_t x;
    rst = 1;
    b.wb_valid = 0; b.wb_waddr = 0; b.wb_wdata = 0;
    b.long_valid = 0; b.long_waddr = 0; b.long_wdata = 0;
    b.issue_valid = 0; b.issue_rd = 0; b.query_rs = 0; b.query_rt = 0;
    step(rstv());
    step(rstv());
    chk("reset_ready", b.long_ready, 1);
    chk("reset_waddr", b.rf_waddr, 0);
    tv[0] = '{mk(1, 5, 'h1234, 0, 0, 0, 0, 0), 1, 5, 'h1234, 1, 0, 0, 0};
    tv[1] = '{mk(0, 0, 0, 0, 0, 0, 1, 9), 0, 0, 0, 1, 1, 1, 0};
    tv[2] = '{mk(0, 0, 0, 1, 9, 'hDEAD, 0, 0), 0, 0, 0, 1, 1, 1, 0};
    tv[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 9, 'hDEAD, 1, 0, 0, 0};
    tv[4] = '{mk(0, 0, 0, 1, 3, 'hA, 0, 0), 0, 0, 0, 1, 0, 1, 0};
    tv[5] = '{mk(1, 6, 'h111, 1, 4, 'hB, 0, 0), 1, 6, 'h111, 1, 0, 1, 0};
    tv[6] = '{mk(1, 7, 'h222, 0, 0, 0, 0, 0), 1, 7, 'h222, 1, 0, 1, 0};
    tv[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 3, 'hA, 1, 0, 1, 0};
    tv[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 4, 'hB, 1, 0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      step(tv[k].i);
      chk($sformatf("tv%0d_wen", k), b.rf_wen, tv[k].e_wen);
      if (tv[k].e_wen) begin
        chk($sformatf("tv%0d_waddr", k), b.rf_waddr, tv[k].e_wa);
        chk($sformatf("tv%0d_wdata", k), b.rf_wdata, tv[k].e_wd);
      end
      chk($sformatf("tv%0d_ready", k), b.long_ready, tv[k].e_rdy);
      chk($sformatf("tv%0d_busy_rs", k), b.busy_rs, tv[k].e_brs);
      chk($sformatf("tv%0d_pany", k), b.pending_any, tv[k].e_pany);
      chk($sformatf("tv%0d_hold", k), b.wb_hold, tv[k].e_hold);
    end
    step(mk(0, 0, 0, 1, 10, 'hC0FFEE, 0, 0));
    step(mk(1, 1, 'h11, 0, 0, 0, 0, 0));
    chk("starve_hold1", b.wb_hold, 0);
    step(mk(1, 2, 'h12, 0, 0, 0, 0, 0));
    chk("starve_hold2", b.wb_hold, 0);
    step(mk(1, 3, 'h13, 0, 0, 0, 0, 0));
    chk("starve_hold_rise", b.wb_hold, 1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("starve_hold_fall", b.wb_hold, 0);
    chk("starve_waddr", b.rf_waddr, 10);
    chk("starve_wdata", b.rf_wdata, 'hC0FFEE);
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 5'(20 + i), 32'(i), 1, 5'(12 + i), 32'('h500 + i), 0, 0));
      chk($sformatf("fill%0d_ready", i), b.long_ready, i < 3);
    end
    chk("full_hold", b.wb_hold, 1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("full_pop_ready", b.long_ready, 1);
    chk("full_pop_data", b.rf_wdata, 'h500);
    step(mk(1, 25, 'h25, 1, 16, 'h504, 0, 0));
    chk("wrap_push_ready", b.long_ready, 0);
    for (int i = 1; i < 5; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0));
      chk($sformatf("wrap%0d_waddr", i), b.rf_waddr, 12 + i);
      chk($sformatf("wrap%0d_wdata", i), b.rf_wdata, 'h500 + i);
    end
    step(mk(0, 0, 0, 1, 0, 'h77, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("r0_wen", b.rf_wen, 0);
    chk("r0_popped", b.pending_any, 0);
    step(mk(1, 1, 1, 1, 17, 'hA1, 1, 17));
    step(mk(1, 2, 2, 1, 18, 'hA2, 1, 18));
    chk("pre_rst_pany", b.pending_any, 1);
    step(rstv());
    chk("rst_mid_ready", b.long_ready, 1);
    chk("rst_mid_pany", b.pending_any, 0);
    chk("rst_mid_wen", b.rf_wen, 0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_mid_nopop", b.rf_wen, 0);
    for (int c = 0; c < 3000; c++) begin
      x = mk(0, 0, 0, 0, 0, 0, 0, 0);
      x.rst = $urandom_range(0, 199) == 0;
      x.wv = !m_hold && $urandom_range(0, 9) < 6;
      x.wa = 5'($urandom_range(0, 31));
      if (pend[x.wa]) x.wa = 0;
      x.wd = $urandom;
      x.lv = $urandom_range(0, 1);
      x.la = 5'($urandom_range(0, 31));
      x.ld = $urandom;
      x.ir = 5'($urandom_range(0, 31));
      x.iv = $urandom_range(0, 9) < 3 && !pend[x.ir];
      x.rs = 5'($urandom_range(0, 31));
      x.rt = 5'($urandom_range(0, 31));
      step(x);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
